// File: rtl/app_gpio_ctrl.sv
// GPIO port on the OPB register bus: output register with set/clear, synchronised
// inputs with per-bit edge capture into sticky W1C status, and a masked interrupt.
//
// state  | meaning
// ARMING | post-reset settle; synchronisers filling, edge capture suppressed
// ARMED  | normal operation; enabled edges latch into EDGE_STATUS
module app_gpio_ctrl #(
   parameter int                 NUM_IN      = 18,
   parameter int                 NUM_OUT     = 13,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_OUT-1:0] OUT_RST_VAL = '0
) (
   input  logic               OPB_CLK,
   input  logic               OPB_RST,
   input  logic [31:0]        OPB_DI,
   input  logic [31:0]        OPB_ADDR,
   output logic [31:0]        OPB_DO,
   input  logic               APP_RE,
   input  logic               APP_WE,
   input  logic [NUM_IN-1:0]  APP_IN,
   output logic [NUM_OUT-1:0] APP_OUT,
   output logic               APP_IRQ
);

   localparam logic [2:0] A_OUT_DATA = 3'd0;
   localparam logic [2:0] A_OUT_SET  = 3'd1;
   localparam logic [2:0] A_OUT_CLR  = 3'd2;
   localparam logic [2:0] A_IN_DATA  = 3'd3;
   localparam logic [2:0] A_EDGE     = 3'd4;
   localparam logic [2:0] A_RISE_EN  = 3'd5;
   localparam logic [2:0] A_FALL_EN  = 3'd6;
   localparam logic [2:0] A_IRQ_EN   = 3'd7;

   localparam int              CNT_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(SYNC_STAGES);

   typedef enum logic {ARMING = 1'b0, ARMED = 1'b1} arm_state_t;

   arm_state_t arm_state;
   logic [CNT_W-1:0] arm_cnt;

   logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q;
   logic [NUM_IN-1:0]  in_sync;
   logic [NUM_IN-1:0]  in_prev;
   logic [NUM_OUT-1:0] out_data;
   logic [NUM_IN-1:0]  edge_status;
   logic [NUM_IN-1:0]  rise_en;
   logic [NUM_IN-1:0]  fall_en;
   logic [NUM_IN-1:0]  irq_en;
   logic [NUM_IN-1:0]  w1c_mask;
   logic [NUM_IN-1:0]  edge_hit;
   logic [NUM_IN-1:0]  edge_next;
   logic [31:0]        rd_data;
   logic [2:0]         reg_sel;
   logic               bus_unused;

   assign reg_sel    = OPB_ADDR[4:2];
   assign in_sync    = sync_q[SYNC_STAGES-1];
   assign APP_OUT    = out_data;
   assign bus_unused = ^{OPB_ADDR[31:5], OPB_ADDR[1:0], OPB_DI};

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         sync_q  <= '0;
         in_prev <= '0;
      end else begin
         sync_q[0] <= APP_IN;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         in_prev <= in_sync;
      end
   end

   // Counts SYNC_STAGES+1 clocks so the chains and in_prev hold real pin values
   // before the first compare; pins tied high then never look like a rise.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         arm_state <= ARMING;
         arm_cnt   <= '0;
      end else begin
         case (arm_state)
            ARMING: begin
               if (arm_cnt == ARM_LAST) begin
                  arm_state <= ARMED;
               end else begin
                  arm_cnt <= arm_cnt + CNT_W'(1);
               end
            end
            ARMED: arm_state <= ARMED;
            default: arm_state <= ARMING;
         endcase
      end
   end

   always_comb begin
      w1c_mask = '0;
      if (APP_WE && (reg_sel == A_EDGE)) begin
         w1c_mask = OPB_DI[NUM_IN-1:0];
      end
      edge_hit = '0;
      if (arm_state == ARMED) begin
         edge_hit = (in_sync & ~in_prev & rise_en) | (~in_sync & in_prev & fall_en);
      end
      // A new edge beats a same-cycle clear so it is never lost.
      edge_next = (edge_status & ~w1c_mask) | edge_hit;
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         A_OUT_DATA: rd_data[NUM_OUT-1:0] = out_data;
         A_IN_DATA:  rd_data[NUM_IN-1:0]  = in_sync;
         A_EDGE:     rd_data[NUM_IN-1:0]  = edge_status;
         A_RISE_EN:  rd_data[NUM_IN-1:0]  = rise_en;
         A_FALL_EN:  rd_data[NUM_IN-1:0]  = fall_en;
         A_IRQ_EN:   rd_data[NUM_IN-1:0]  = irq_en;
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         OPB_DO      <= '0;
         out_data    <= OUT_RST_VAL;
         edge_status <= '0;
         rise_en     <= '0;
         fall_en     <= '0;
         irq_en      <= '0;
         APP_IRQ     <= 1'b0;
      end else begin
         if (APP_RE) begin
            OPB_DO <= rd_data;
         end
         if (APP_WE) begin
            case (reg_sel)
               A_OUT_DATA: out_data <= OPB_DI[NUM_OUT-1:0];
               A_OUT_SET:  out_data <= out_data | OPB_DI[NUM_OUT-1:0];
               A_OUT_CLR:  out_data <= out_data & ~OPB_DI[NUM_OUT-1:0];
               A_RISE_EN:  rise_en  <= OPB_DI[NUM_IN-1:0];
               A_FALL_EN:  fall_en  <= OPB_DI[NUM_IN-1:0];
               A_IRQ_EN:   irq_en   <= OPB_DI[NUM_IN-1:0];
               default: ;
            endcase
         end
         edge_status <= edge_next;
         APP_IRQ     <= |(edge_status & irq_en);
      end
   end

endmodule

// File: tb/tb_app_gpio_ctrl.sv
// Directed bench for app_gpio_ctrl: register access, set/clear, edge capture latency,
// W1C vs edge priority, read/write collision, async reset and arming.
module tb_app_gpio_ctrl;

   localparam int         NI      = 18;
   localparam int         NO      = 13;
   localparam logic [12:0] RST_OUT = 13'h00A5;

   localparam logic [2:0] A_OUT  = 3'd0;
   localparam logic [2:0] A_SET  = 3'd1;
   localparam logic [2:0] A_CLR  = 3'd2;
   localparam logic [2:0] A_IN   = 3'd3;
   localparam logic [2:0] A_EDGE = 3'd4;
   localparam logic [2:0] A_RISE = 3'd5;
   localparam logic [2:0] A_FALL = 3'd6;
   localparam logic [2:0] A_IRQ  = 3'd7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   di = '0;
   logic [31:0]   addr = '0;
   logic [31:0]   dout;
   logic          re = 1'b0;
   logic          we = 1'b0;
   logic [NI-1:0] app_in = '1;
   logic [NO-1:0] app_out;
   logic          irq;
   logic [31:0]   r;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   app_gpio_ctrl #(
      .NUM_IN(NI), .NUM_OUT(NO), .SYNC_STAGES(2), .OUT_RST_VAL(RST_OUT)
   ) dut (
      .OPB_CLK(clk), .OPB_RST(rst), .OPB_DI(di), .OPB_ADDR(addr), .OPB_DO(dout),
      .APP_RE(re), .APP_WE(we), .APP_IN(app_in), .APP_OUT(app_out), .APP_IRQ(irq)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr = {27'd0, a, 2'b00};
      di   = d;
      we   = 1'b1;
      tick;
      we   = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      addr = {27'd0, a, 2'b00};
      re   = 1'b1;
      tick;
      re   = 1'b0;
      d    = dout;
   endtask

   initial begin
      // reset with all inputs high
      tick;
      tick;
      chk("rst_do", dout, 32'h0);
      chk("rst_out", {19'd0, app_out}, {19'd0, RST_OUT});
      chk("rst_irq", {31'd0, irq}, 32'h0);
      rst = 1'b0;
      wr(A_RISE, 32'hFFFF_FFFF);
      wr(A_IRQ, 32'h0003_FFFF);
      repeat (4) tick;
      rd(A_EDGE, r);  chk("arm_no_rise", r, 32'h0);
      rd(A_IN, r);    chk("in_data_high", r, 32'h0003_FFFF);
      chk("arm_irq", {31'd0, irq}, 32'h0);
      rd(A_RISE, r);  chk("rise_en_width", r, 32'h0003_FFFF);

      // output register, set/clear, width masking
      wr(A_OUT, 32'hFFFF_FFFF);
      rd(A_OUT, r);   chk("out_width", r, 32'h0000_1FFF);
      wr(A_OUT, 32'h0000_0A5A);
      chk("out_write", {19'd0, app_out}, 32'h0A5A);
      wr(A_SET, 32'h0000_1001);
      chk("out_set", {19'd0, app_out}, 32'h1A5B);
      wr(A_CLR, 32'h0000_0002);
      chk("out_clr", {19'd0, app_out}, 32'h1A59);
      rd(A_OUT, r);   chk("out_readback", r, 32'h0000_1A59);
      rd(A_SET, r);   chk("set_reads0", r, 32'h0);
      rd(A_CLR, r);   chk("clr_reads0", r, 32'h0);
      wr(A_SET, 32'h0000_0004);
      chk("set_b2", {19'd0, app_out}, 32'h1A5D);
      wr(A_CLR, 32'h0000_0004);
      chk("clr_b2_next", {19'd0, app_out}, 32'h1A59);

      // rise on bit 0, latency and W1C
      wr(A_RISE, 32'h1);
      wr(A_IRQ, 32'h1);
      app_in[0] = 1'b0;
      repeat (4) tick;
      chk("fall_disabled_irq", {31'd0, irq}, 32'h0);
      app_in[0] = 1'b1;
      tick;
      tick;
      addr = {27'd0, A_EDGE, 2'b00};
      re = 1'b1;
      tick;
      chk("edge_before_e2", dout, 32'h0);
      chk("irq_before_e3", {31'd0, irq}, 32'h0);
      tick;
      re = 1'b0;
      chk("edge_at_e2", dout, 32'h1);
      chk("irq_at_e3", {31'd0, irq}, 32'h1);
      wr(A_EDGE, 32'h1);
      chk("irq_hold_w1c", {31'd0, irq}, 32'h1);
      tick;
      chk("irq_clear_w1c", {31'd0, irq}, 32'h0);
      rd(A_EDGE, r);  chk("edge_cleared", r, 32'h0);

      // fall on bit 2 collides with W1C of bit 2; bit 5 falls but is not enabled
      wr(A_FALL, 32'h4);
      app_in[2] = 1'b0;
      app_in[5] = 1'b0;
      tick;
      tick;
      wr(A_EDGE, 32'h4);
      rd(A_EDGE, r);  chk("edge_wins_w1c", r, 32'h4);
      wr(A_EDGE, 32'h4);
      rd(A_EDGE, r);  chk("w1c_b2", r, 32'h0);

      // interrupt drops one cycle after enable clear
      app_in[0] = 1'b0;
      repeat (3) tick;
      app_in[0] = 1'b1;
      repeat (4) tick;
      chk("irq_rise_again", {31'd0, irq}, 32'h1);
      wr(A_IRQ, 32'h0);
      chk("irq_hold_en", {31'd0, irq}, 32'h1);
      tick;
      chk("irq_clear_en", {31'd0, irq}, 32'h0);

      // simultaneous read and write
      wr(A_OUT, 32'h3);
      addr = {27'd0, A_OUT, 2'b00};
      di = 32'h10;
      re = 1'b1;
      we = 1'b1;
      tick;
      re = 1'b0;
      we = 1'b0;
      chk("rw_old_value", dout, 32'h3);
      chk("rw_new_out", {19'd0, app_out}, 32'h10);
      wr(A_OUT, 32'h7);
      chk("do_holds", dout, 32'h3);
      chk("out_7", {19'd0, app_out}, 32'h7);

      // async reset mid-cycle with irq active
      wr(A_IRQ, 32'h1);
      tick;
      chk("irq_before_rst", {31'd0, irq}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_irq", {31'd0, irq}, 32'h0);
      chk("async_do", dout, 32'h0);
      chk("async_out", {19'd0, app_out}, {19'd0, RST_OUT});
      app_in = '1;
      tick;
      tick;
      rst = 1'b0;
      wr(A_RISE, 32'h0003_FFFF);
      wr(A_IRQ, 32'h0003_FFFF);
      repeat (4) tick;
      rd(A_EDGE, r);  chk("rearm_no_rise", r, 32'h0);
      chk("rearm_irq", {31'd0, irq}, 32'h0);
      app_in[3] = 1'b0;
      repeat (3) tick;
      app_in[3] = 1'b1;
      repeat (4) tick;
      rd(A_EDGE, r);  chk("post_arm_rise", r, 32'h8);
      chk("post_arm_irq", {31'd0, irq}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
